// File: rtl/tmds_clk_pkg.sv
// Shared constants and helpers for the TMDS I/O clocking block.
package tmds_clk_pkg;
   localparam int DIVIDE_MIN = 2;
   localparam int DIVIDE_MAX = 8;

   localparam int LANE_BLUE  = 0;
   localparam int LANE_GREEN = 1;
   localparam int LANE_RED   = 2;
   localparam int LANE_CLK   = 3;

   // Phase counter width; never narrower than one bit.
   function automatic int phase_w(input int divide);
      return (divide <= 2) ? 1 : $clog2(divide);
   endfunction
endpackage

// File: rtl/tmds_io_clocking_lock_qualifier.sv
// Two-flop synchronizer on the PLL lock plus a saturating qualification counter.
module lock_qualifier #(
   parameter int LOCK_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic locked_i,
   output logic lock_o,
   output logic lock_d_o
);
   localparam logic [7:0] CNT_LAST = 8'(LOCK_CYCLES - 1);

   logic       sync1_q, sync2_q;
   logic [7:0] cnt_q, cnt_d;
   logic       lock_q, lock_d;

   always_comb begin
      cnt_d  = '0;
      lock_d = 1'b0;
      // Any synchronized low drops lock immediately; there is no hysteresis.
      if (sync2_q) begin
         cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
         lock_d = lock_q | (cnt_q == CNT_LAST);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         lock_q  <= 1'b0;
      end else begin
         sync1_q <= locked_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
      end
   end

   assign lock_o   = lock_q;
   assign lock_d_o = lock_d;
endmodule

// File: rtl/tmds_io_clocking.sv
// Fast-clock domain clocking for the TMDS serializer: lock, word strobe,
// divided phase reference, SERDES reset and complementary lane drivers.
module tmds_io_clocking
   import tmds_clk_pkg::*;
#(
   parameter int DIVIDE      = 5,
   parameter int LOCK_CYCLES = 16,
   parameter int LANES       = 4
) (
   input  logic             pll_clk,
   input  logic             reset,
   input  logic             pll_locked,
   output logic             lock,
   output logic             serdes_strobe,
   output logic             gclk_div,
   output logic             serdes_reset,
   input  logic [LANES-1:0] lane_in,
   output logic [LANES-1:0] tmds_p,
   output logic [LANES-1:0] tmds_n
);
   localparam int            PW         = phase_w(DIVIDE);
   localparam logic [PW-1:0] PHASE_LAST = PW'(DIVIDE - 1);
   localparam logic [PW-1:0] PHASE_HALF = PW'((DIVIDE + 1) / 2);

   if (DIVIDE < DIVIDE_MIN || DIVIDE > DIVIDE_MAX) begin : g_bad_divide
      $error("tmds_io_clocking: DIVIDE out of range");
   end

   logic          lock_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          strobe_q, strobe_d;
   logic          gdiv_q, gdiv_d;

   lock_qualifier #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_qualifier (
      .clk_i    (pll_clk),
      .rst_i    (reset),
      .locked_i (pll_locked),
      .lock_o   (lock),
      .lock_d_o (lock_d)
   );

   // Outputs are computed from next-state so they line up with the phase register.
   always_comb begin
      phase_d = '0;
      if (lock_d && lock)
         phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      strobe_d = lock_d && (phase_d == PHASE_LAST);
      gdiv_d   = lock_d && (phase_d < PHASE_HALF);
   end

   always_ff @(posedge pll_clk or posedge reset) begin
      if (reset) begin
         phase_q  <= '0;
         strobe_q <= 1'b0;
         gdiv_q   <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         strobe_q <= strobe_d;
         gdiv_q   <= gdiv_d;
      end
   end

   assign serdes_strobe = strobe_q;
   assign gclk_div      = gdiv_q;
   assign serdes_reset  = reset | ~lock;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign tmds_p[i] = lane_in[i];
      assign tmds_n[i] = ~lane_in[i];
   end
endmodule

// File: tb/tb_tmds_io_clocking.sv
// Directed scoreboard bench: three instances (DIVIDE 5, 2, 8) share stimulus.
module tb_tmds_io_clocking;
   localparam int LC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       plk;
   logic [3:0] lane;

   logic       l5, s5, g5, r5, l2, s2, g2, r2, l8, s8, g8, r8;
   logic [3:0] p5, n5, p2, n2, p8, n8;

   int vectors = 0;
   int miscompares = 0;
   logic [11:0] sb[$];

   always #5 clk = ~clk;

   tmds_io_clocking #(.DIVIDE(5), .LOCK_CYCLES(LC), .LANES(4)) u_d5 (
      .pll_clk(clk), .reset(rst), .pll_locked(plk), .lock(l5), .serdes_strobe(s5),
      .gclk_div(g5), .serdes_reset(r5), .lane_in(lane), .tmds_p(p5), .tmds_n(n5));
   tmds_io_clocking #(.DIVIDE(2), .LOCK_CYCLES(LC), .LANES(4)) u_d2 (
      .pll_clk(clk), .reset(rst), .pll_locked(plk), .lock(l2), .serdes_strobe(s2),
      .gclk_div(g2), .serdes_reset(r2), .lane_in(lane), .tmds_p(p2), .tmds_n(n2));
   tmds_io_clocking #(.DIVIDE(8), .LOCK_CYCLES(LC), .LANES(4)) u_d8 (
      .pll_clk(clk), .reset(rst), .pll_locked(plk), .lock(l8), .serdes_strobe(s8),
      .gclk_div(g8), .serdes_reset(r8), .lane_in(lane), .tmds_p(p8), .tmds_n(n8));

   wire [11:0] obs = {l5, s5, g5, r5, l2, s2, g2, r2, l8, s8, g8, r8};

   // Expected {lock, strobe, gclk_div, serdes_reset} after edge e of a steady-high lock.
   function automatic logic [3:0] part(input int d, input int e);
      int p;
      if (e < LC + 2) return 4'b0001;
      p = (e - LC - 2) % d;
      return {1'b1, (p == d - 1), (p < (d + 1) / 2), 1'b0};
   endfunction

   function automatic logic [11:0] ex(input int e);
      return {part(5, e), part(2, e), part(8, e)};
   endfunction

   task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] x);
      vectors++;
      assert (o === x) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, o, x);
      end
   endtask

   task automatic cyc(input logic [11:0] x);
      logic [11:0] want;
      sb.push_back(x);
      @(negedge clk);
      want = sb.pop_front();
      chk("sb", obs, want);
   endtask

   task automatic lanes_chk(input logic [3:0] v);
      lane = v;
      #1;
      chk("tmds_p", {p8, p2, p5}, {v, v, v});
      chk("tmds_n", {n8, n2, n5}, {~v, ~v, ~v});
   endtask

   initial begin
      rst  = 1'b1;
      plk  = 1'b0;
      lane = 4'b1010;
      repeat (3) @(negedge clk);
      plk = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_state", obs, ex(0));
      chk("reset_tmds", {4'b0, p5, n5}, {4'b0, 4'b1010, 4'b0101});
      lanes_chk(4'b0110);
      @(negedge clk);
      lanes_chk(4'b1111);
      @(negedge clk);
      lanes_chk(4'b1010);

      // Release with pll_locked already high: the next edge is edge 1.
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 60; e++) cyc(ex(e));
      lanes_chk(4'b0101);

      // Drop while phase==2 (DIVIDE 5), then relock from scratch.
      plk = 1'b0;
      cyc(ex(61));
      cyc(ex(62));
      repeat (2) cyc(ex(0));
      plk = 1'b1;
      for (int e = 1; e <= 40; e++) cyc(ex(e));

      // Short lock pulse never qualifies.
      plk = 1'b0;
      cyc(ex(41));
      cyc(ex(42));
      repeat (5) cyc(ex(0));
      plk = 1'b1;
      repeat (10) cyc(ex(0));
      plk = 1'b0;
      repeat (20) cyc(ex(0));

      // Relock, then assert reset asynchronously mid-word.
      plk = 1'b1;
      for (int e = 1; e <= 22; e++) cyc(ex(e));
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", obs, ex(0));
      @(negedge clk);
      chk("reset_held", obs, ex(0));
      rst = 1'b0;
      for (int e = 1; e <= 20; e++) cyc(ex(e));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tmds_io_clocking.md
# tmds_io_clocking

- Synthesizable clocking and output-driver block for the DVI/TMDS serializer path; sits between the video PLL and the output pins.
- Runs on the fast I/O clock and derives from it a qualified lock, a SERDES strobe, a divided phase-reference waveform and a SERDES reset.
- Drives each TMDS lane as a complementary pair.
- Replaces the separate global-buffer, I/O-PLL-buffer and differential-output functions with one clock-domain block.

## Interface
Parameters:
- DIVIDE, 5: fast-clock cycles per SERDES word; legal range 2..8.
- LOCK_CYCLES, 16: consecutive synchronized-lock cycles required before `lock` asserts; legal range 1..255.
- LANES, 4: number of differential output lanes (blue, green, red, clock).

Ports (one clock; reset is asynchronous and active-high):
- pll_clk  in  1  fast I/O clock; all registers on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pll_locked  in  1  PLL lock; asynchronous to pll_clk.
- lock  out  1  qualified lock, registered.
- serdes_strobe  out  1  one-cycle word-boundary pulse, registered.
- gclk_div  out  1  divided phase reference, period DIVIDE, registered.
- serdes_reset  out  1  `reset | ~lock`, combinational.
- lane_in  in  LANES  serial bit per lane.
- tmds_p  out  LANES  true leg.
- tmds_n  out  LANES  complement leg.

## Operation
- **Synchronizer.** `pll_locked` passes through a 2-flop synchronizer to give `lk_s`.
- **Lock counter.**
  - Saturating counter `lk_cnt`, 8 bits.
  - While `lk_s`=1, increments each edge.
  - Set `lock` at the edge where `lk_s`=1 and `lk_cnt`==LOCK_CYCLES-1.
  - `lk_s`=0 clears `lk_cnt` and `lock` at that same edge; no hysteresis.
- **Phase counter.**
  - Width is clog2(DIVIDE).
  - Held at 0 while `lock`=0.
  - While `lock`=1, counts 0..DIVIDE-1 and wraps to 0.
- **serdes_strobe.** Register loaded with (next phase == DIVIDE-1) && next lock; it is therefore high exactly during the cycle phase==DIVIDE-1.
- **gclk_div.** Register loaded with next lock && (next phase < ceil(DIVIDE/2)).
  - DIVIDE=5 gives 3 cycles high, 2 low.
  - Low whenever `lock`=0.
- **Loss of lock.** When lock drops mid-word, the phase counter, strobe and gclk_div return to 0 on the same edge that clears `lock`. Relock restarts at phase 0.
- **serdes_reset.** `serdes_reset = reset | ~lock`.
- **Differential lanes.** `tmds_p = lane_in`, `tmds_n = ~lane_in`, combinational and unaffected by reset or lock.
  - Lane order: index 0 blue, 1 green, 2 red, 3 clock.
- **Reset values.** lock=0, serdes_strobe=0, gclk_div=0, serdes_reset=1, all counters and synchronizer flops 0.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples `pll_locked`=1 (steady high thereafter).
  - `lk_s` is high from edge 2.
  - `lock` rises at edge LOCK_CYCLES+2, i.e. edge 18 by default.
- Cycle numbering: cycle 1 is the first cycle with `lock`=1, and phase=0 in it.
  - First `serdes_strobe` is in cycle DIVIDE (cycle 5 by default).
  - Strobes then repeat every DIVIDE cycles.
- `pll_locked` falling: `lock` falls 2 edges later (synchronizer latency). `serdes_strobe` and `gclk_div` are low from that same edge.
- `reset` assertion forces all registered outputs to reset values immediately, with no clock required. Deassertion is synchronous to pll_clk; the integrator supplies a synchronized release.
- `serdes_reset` follows `reset` combinationally and follows `lock` with zero added latency.

## Structure
- Shared package `tmds_clk_pkg`:
  - DIVIDE_MIN=2, DIVIDE_MAX=8.
  - LANE_BLUE=0, LANE_GREEN=1, LANE_RED=2, LANE_CLK=3.
  - A clog2-based phase-width function.
- One sub-module `lock_qualifier`: the 2-flop synchronizer plus saturating lock counter, producing `lock`.
- Phase counter, strobe, gclk_div and lane drivers stay in the top level.

## Test plan
- Reset held, `pll_locked`=1, lane_in=4'b1010 -> lock=0, strobe=0, gclk_div=0, serdes_reset=1, tmds_p=1010, tmds_n=0101.
- Release reset, `pll_locked` high from edge 1 -> lock rises at edge 18, serdes_reset falls with it, first strobe in cycle 5, strobe then every 5 cycles, gclk_div pattern 11100 repeating.
- `pll_locked` pulse of 10 cycles then low (LOCK_CYCLES=16) -> lock never asserts, no strobes.
- Drop `pll_locked` while phase=2, then restore -> lock, strobe and gclk_div low 2 edges later; after a 16+2-edge relock the phase restarts at 0 and the first strobe is again in cycle 5.
- DIVIDE=2 -> strobe high every second cycle, gclk_div pattern 10. DIVIDE=8 -> strobe every 8 cycles, gclk_div pattern 11110000.
- Assert `reset` asynchronously mid-word while locked -> all registered outputs reach reset values before the next clock edge, and serdes_reset=1 immediately.
